// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared encodings for the execute stage.
//   - ALU op codes, operand-select and memory-op encodings
//   - FSM state type for the serial shift sequencer
//   - EX/MEM boundary record and its bubble value
package ex_stage_pkg;

  localparam int EX_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;

  typedef enum logic [1:0] {
    SEL_B_RS2  = 2'b00,
    SEL_B_IMM  = 2'b01,
    SEL_B_FOUR = 2'b10,
    SEL_B_ZERO = 2'b11
  } sel_b_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic [EX_XLEN-1:0] alu_result;
    logic [EX_XLEN-1:0] store_data;
    logic [1:0]         mem_op;
    logic [1:0]         mem_size;
    logic [4:0]         rd;
    logic               alu_to_reg;
  } ex_mem_t;

  // memOp = none and aluToReg = 0 make the record a no-op downstream.
  localparam ex_mem_t EXMEM_BUBBLE = '0;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/ex_stage_serial_shifter.sv
// serial_shifter: 1 bit/cycle shifter with a down-counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : capture i_a, i_n and direction controls
//   i_a, i_n       : value to shift and shift amount (i_n >= 1)
//   i_left         : 1 = shift left, 0 = shift right
//   i_arith        : right shifts fill with the sign bit
//   i_hold         : freeze shift register and count
//   o_done         : last shift step is pending this cycle
//   o_result       : value after the pending step (final result when o_done)
module serial_shifter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_a,
  input  logic [$clog2(XLEN)-1:0] i_n,
  input  logic            i_left,
  input  logic            i_arith,
  input  logic            i_hold,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] r_sh;
  logic [CW-1:0]   r_cnt;
  logic            r_left;
  logic            r_arith;
  logic [XLEN-1:0] w_next;

  assign w_next   = r_left ? {r_sh[XLEN-2:0], 1'b0}
                           : {(r_arith & r_sh[XLEN-1]), r_sh[XLEN-1:1]};
  assign o_done   = (r_cnt == CW'(1));
  assign o_result = w_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_sh    <= i_a;
      r_cnt   <= i_n;
      r_left  <= i_left;
      r_arith <= i_arith;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_sh  <= w_next;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the in-order RISC-V pipeline.
//   clk, reset          : clock, async active-low reset
//   rs1Data..pc         : operands from regfile / ID/EX latch
//   selA, selB, aluOp   : operand selects and ALU operation
//   memOp, memSize, rd, aluToReg : control carried into EX/MEM
//   stallIn             : MEM stall; freezes this stage
//   stallOut            : stall request upstream (combinational)
//   aluResult..aluToRegOut : registered EX/MEM outputs
// Non-zero shifts run through a serial shifter; a bubble is issued on the
// load edge and the real record is written on the final shift edge.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            selA,
  input  logic [1:0]      selB,
  input  logic [3:0]      aluOp,
  input  logic [1:0]      memOp,
  input  logic [1:0]      memSize,
  input  logic [4:0]      rd,
  input  logic            aluToReg,
  input  logic            stallIn,
  output logic            stallOut,
  output logic [XLEN-1:0] aluResult,
  output logic [XLEN-1:0] storeData,
  output logic [1:0]      memOpOut,
  output logic [1:0]      memSizeOut,
  output logic [4:0]      rdOut,
  output logic            aluToRegOut
);

  ex_state_e       r_state;
  ex_mem_t         r_exm;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_start;
  logic            w_stall_int;
  logic            w_sh_done;
  logic [XLEN-1:0] w_sh_result;
  ex_mem_t         w_exm;

  // Operand muxes
  assign w_a = (selA == SEL_A_PC) ? pc : rs1Data;

  always_comb begin
    w_b = '0;
    case (selB)
      SEL_B_RS2:  w_b = rs2Data;
      SEL_B_IMM:  w_b = imm;
      SEL_B_FOUR: w_b = XLEN'(4);
      default:    w_b = '0;
    endcase
  end

  assign w_shamt = w_b[4:0];

  // Single-cycle ALU. Shift ops only reach here with shamt = 0, where the
  // result is simply A; non-zero shifts go through the serial shifter.
  always_comb begin
    w_alu = '0;
    case (aluOp)
      ALU_ADD:   w_alu = w_a + w_b;
      ALU_SUB:   w_alu = w_a - w_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   w_alu = w_a;
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_AND:   w_alu = w_a & w_b;
      ALU_PASSB: w_alu = w_b;
      default:   w_alu = '0;
    endcase
  end

  assign w_start     = (r_state == ST_IDLE) && is_shift(aluOp) && (w_shamt != 5'd0);
  assign w_stall_int = w_start || ((r_state == ST_SHIFT) && !w_sh_done);
  assign stallOut    = reset & (w_stall_int | stallIn);

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_load   (w_start && !stallIn),
    .i_a      (w_a),
    .i_n      (w_shamt),
    .i_left   (aluOp == ALU_SLL),
    .i_arith  (aluOp == ALU_SRA),
    .i_hold   (stallIn),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

  // Record written on completion; ID/EX inputs are still held by stallOut
  // when a shift finishes, so they are sampled here in both cases.
  always_comb begin
    w_exm            = EXMEM_BUBBLE;
    w_exm.alu_result = (r_state == ST_SHIFT) ? w_sh_result : w_alu;
    w_exm.store_data = rs2Data;
    w_exm.mem_op     = (memOp == MEM_RSVD) ? MEM_NONE : memOp;
    w_exm.mem_size   = memSize;
    w_exm.rd         = rd;
    w_exm.alu_to_reg = aluToReg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_exm   <= EXMEM_BUBBLE;
    end else if (!stallIn) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_exm   <= EXMEM_BUBBLE;
            r_state <= ST_SHIFT;
          end else begin
            r_exm   <= w_exm;
          end
        end
        ST_SHIFT: begin
          if (w_sh_done) begin
            r_exm   <= w_exm;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign aluResult   = r_exm.alu_result;
  assign storeData   = r_exm.store_data;
  assign memOpOut    = r_exm.mem_op;
  assign memSizeOut  = r_exm.mem_size;
  assign rdOut       = r_exm.rd;
  assign aluToRegOut = r_exm.alu_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rs1Data = '0, rs2Data = '0, imm = '0, pc = '0;
  logic        selA = 1'b0;
  logic [1:0]  selB = '0;
  logic [3:0]  aluOp = '0;
  logic [1:0]  memOp = '0, memSize = '0;
  logic [4:0]  rd = '0;
  logic        aluToReg = 1'b0;
  logic        stallIn = 1'b0;
  logic        stallOut;
  logic [31:0] aluResult, storeData;
  logic [1:0]  memOpOut, memSizeOut;
  logic [4:0]  rdOut;
  logic        aluToRegOut;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm), .pc(pc),
    .selA(selA), .selB(selB), .aluOp(aluOp), .memOp(memOp), .memSize(memSize), .rd(rd),
    .aluToReg(aluToReg), .stallIn(stallIn), .stallOut(stallOut), .aluResult(aluResult),
    .storeData(storeData), .memOpOut(memOpOut), .memSizeOut(memSizeOut), .rdOut(rdOut),
    .aluToRegOut(aluToRegOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [1:0]  mo;
    logic [1:0]  ms;
    logic [4:0]  rd;
    logic        a2r;
    int          nstall;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad = 0;
  bit    drv_active = 0;
  int    stall_pct = 0;
  logic [31:0] stall_sched = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: instruction semantics straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] r1, r2, im, p, input logic sa,
                                 input logic [1:0] sb, input logic [3:0] op,
                                 input logic [1:0] mo, ms, input logic [4:0] d,
                                 input logic a2r);
    exp_t e;
    logic [31:0] a, b;
    int sh;
    a = sa ? p : r1;
    case (sb)
      2'd0: b = r2;
      2'd1: b = im;
      2'd2: b = 32'd4;
      default: b = 32'd0;
    endcase
    sh = int'(b % 32);
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a << sh;
      4'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd5:  e.res = a ^ b;
      4'd6:  e.res = a >> sh;
      4'd7:  e.res = 32'($signed(a) >>> sh);
      4'd8:  e.res = a | b;
      4'd9:  e.res = a & b;
      4'd10: e.res = b;
      default: e.res = 32'd0;
    endcase
    e.nstall = (op == 4'd2 || op == 4'd6 || op == 4'd7) ? sh : 0;
    e.sd  = r2;
    e.mo  = (mo == 2'd3) ? 2'd0 : mo;
    e.ms  = ms;
    e.rd  = d;
    e.a2r = a2r;
    return e;
  endfunction

  // Monitor / scoreboard: each negedge compares the outputs of the last edge
  // against the expected record, then predicts what the coming edge does.
  exp_t exp_cur;
  bit   exp_full = 1;
  bit   exp_known = 0;
  int   scnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      scnt = 0;
      exp_cur = '{res: 0, sd: 0, mo: 0, ms: 0, rd: 0, a2r: 0, nstall: 0};
      exp_full = 1;
      exp_known = 1;
      chk("reset_stallOut", 32'(stallOut), 32'd0);
    end
    if (exp_known) begin
      chk("memOpOut", 32'(memOpOut), 32'(exp_cur.mo));
      chk("rdOut", 32'(rdOut), 32'(exp_cur.rd));
      chk("aluToRegOut", 32'(aluToRegOut), 32'(exp_cur.a2r));
      if (exp_full) begin
        chk("aluResult", aluResult, exp_cur.res);
        chk("storeData", storeData, exp_cur.sd);
        chk("memSizeOut", 32'(memSizeOut), 32'(exp_cur.ms));
      end
    end
    if (reset) begin
      if (!drv_active) exp_known = 0;
      else if (stallIn) exp_known = 1;
      else if (stallOut) begin
        exp_cur.mo = 0; exp_cur.rd = 0; exp_cur.a2r = 0;
        exp_full = 0;
        scnt++;
        exp_known = 1;
      end else if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
        exp_known = 0;
      end else begin
        exp_cur = q.pop_front();
        exp_full = 1;
        chk("stall_cycles", 32'(scnt), 32'(exp_cur.nstall));
        scnt = 0;
        exp_known = 1;
      end
    end
  end

  task automatic drive(input logic [31:0] r1, r2, im, p, input logic sa, input logic [1:0] sb,
                       input logic [3:0] op, input logic [1:0] mo, ms, input logic [4:0] d,
                       input logic a2r, output exp_t e);
    rs1Data = r1; rs2Data = r2; imm = im; pc = p; selA = sa; selB = sb; aluOp = op;
    memOp = mo; memSize = ms; rd = d; aluToReg = a2r;
    e = model(r1, r2, im, p, sa, sb, op, mo, ms, d, a2r);
  endtask

  // Holds the presented instruction until an edge consumes it; returns edges.
  task automatic wait_accept(output int edges);
    bit acc;
    edges = 0;
    acc = 0;
    while (!acc) begin
      stallIn = ((edges < 32) ? stall_sched[edges] : 1'b0) || ($urandom_range(99) < stall_pct);
      @(negedge clk);
      acc = !stallOut && !stallIn;
      @(posedge clk);
      #1;
      edges++;
      if (!acc && edges >= 300) begin
        chk("accept_timeout", 32'(edges), 32'd0);
        acc = 1;
      end
    end
    stallIn = 1'b0;
  endtask

  task automatic issue(input logic [31:0] r1, r2, im, p, input logic sa, input logic [1:0] sb,
                       input logic [3:0] op, input logic [1:0] mo, ms, input logic [4:0] d,
                       input logic a2r, output int edges);
    exp_t e;
    drive(r1, r2, im, p, sa, sb, op, mo, ms, d, a2r, e);
    q.push_back(e);
    wait_accept(edges);
  endtask

  initial begin
    int   n;
    exp_t e;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drv_active = 1;

    // ADD rs1 + imm
    issue(32'd5, 32'd0, 32'd7, 32'h0, 1'b0, 2'b01, 4'd0, 2'b00, 2'b00, 5'd3, 1'b1, n);
    chk("add_result", aluResult, 32'd12);
    chk("add_rd", 32'(rdOut), 32'd3);
    chk("add_edges", 32'(n), 32'd1);

    // SLL 1 by 4: four stall cycles, result on the 5th edge
    issue(32'd1, 32'd4, 32'd0, 32'h0, 1'b0, 2'b00, 4'd2, 2'b00, 2'b00, 5'd7, 1'b1, n);
    chk("sll_result", aluResult, 32'd16);
    chk("sll_edges", 32'(n), 32'd5);

    // SRA 0x80000000 by 31
    issue(32'h8000_0000, 32'd31, 32'd0, 32'h0, 1'b0, 2'b00, 4'd7, 2'b00, 2'b00, 5'd9, 1'b1, n);
    chk("sra_result", aluResult, 32'hFFFF_FFFF);
    chk("sra_edges", 32'(n), 32'd32);

    // SLT vs SLTU
    issue(32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0, 2'b00, 4'd3, 2'b00, 2'b00, 5'd1, 1'b1, n);
    chk("slt_result", aluResult, 32'd1);
    issue(32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0, 2'b00, 4'd4, 2'b00, 2'b00, 5'd1, 1'b1, n);
    chk("sltu_result", aluResult, 32'd0);

    // Shift amount zero (imm = 32 -> shamt 0): single cycle, no stall
    issue(32'h1234_5678, 32'd0, 32'd32, 32'h0, 1'b0, 2'b01, 4'd6, 2'b00, 2'b00, 5'd2, 1'b1, n);
    chk("shamt0_result", aluResult, 32'h1234_5678);
    chk("shamt0_edges", 32'(n), 32'd1);

    // SRL 0xF0 by 4 with a 3-cycle downstream stall after the first shift
    stall_sched = 32'b1_1100;
    issue(32'hF0, 32'd4, 32'd0, 32'h0, 1'b0, 2'b00, 4'd6, 2'b00, 2'b00, 5'd4, 1'b1, n);
    stall_sched = '0;
    chk("srl_stall_result", aluResult, 32'h0F);
    chk("srl_stall_edges", 32'(n), 32'd8);

    // Store address generation with pass-through of store data
    issue(32'h100, 32'hDEAD_BEEF, 32'd8, 32'h0, 1'b0, 2'b01, 4'd0, 2'b10, 2'b10, 5'd0, 1'b0, n);
    chk("store_addr", aluResult, 32'h108);
    chk("store_data", storeData, 32'hDEAD_BEEF);
    chk("store_memop", 32'(memOpOut), 32'd2);

    // Async reset in the middle of a shift, then the held op re-executes
    drive(32'hF0F0, 32'd10, 32'd0, 32'h0, 1'b0, 2'b00, 4'd6, 2'b01, 2'b01, 5'd5, 1'b1, e);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_stallOut", 32'(stallOut), 32'd0);
    chk("midrst_result", aluResult, 32'd0);
    chk("midrst_memop", 32'(memOpOut), 32'd0);
    chk("midrst_a2r", 32'(aluToRegOut), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    q.push_back(e);
    wait_accept(n);
    chk("rerun_result", aluResult, 32'h3C);
    chk("rerun_edges", 32'(n), 32'd11);
    issue(32'd40, 32'd2, 32'd0, 32'h0, 1'b0, 2'b00, 4'd0, 2'b00, 2'b00, 5'd6, 1'b1, n);
    chk("post_rst_add", aluResult, 32'd42);

    // Randomized instructions with random downstream stalls
    stall_pct = 20;
    for (int i = 0; i < 60; i++) begin
      issue($urandom, $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom), 4'($urandom),
            2'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), n);
    end
    stall_pct = 0;

    drv_active = 0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the in-order RISC-V pipeline. It sits directly downstream of the ID/EX operand latch and consumes its registered control and operand fields plus the register-file read data. It selects ALU operands, computes the result, and registers it with the memory and writeback control into the EX/MEM boundary. Shifts run on an area-saving serial shifter (1 bit/cycle), and the stage stalls upstream while a shift is in progress.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- rs1Data, rs2Data  in  XLEN  register-file read data for the instruction in ID/EX.
- imm, pc  in  XLEN  immediate and PC from the ID/EX latch.
- selA  in  1  operand A select: 0 = rs1Data, 1 = pc.
- selB  in  2  operand B select: 00 = rs2Data, 01 = imm, 10 = constant 4, 11 = 0.
- aluOp  in  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; codes 11–15 produce 0.
- memOp, memSize  in  2  00 none, 01 load, 10 store, 11 treated as none. memSize is passed through unchanged.
- rd  in  5  destination register.
- aluToReg  in  1  writeback-from-ALU flag.
- stallIn  in  1  downstream (MEM) stall.
- stallOut  out  1  stall request to ID/EX and earlier stages.
- aluResult, storeData  out  XLEN  registered result and rs2Data.
- memOpOut, memSizeOut  out  2  registered memory control.
- rdOut  out  5  registered destination register.
- aluToRegOut  out  1  registered writeback flag.

## Operation
- Reset (reset = 0):
  - All registered outputs clear to 0; memOpOut = 00 and aluToRegOut = 0 define a bubble.
  - The FSM goes to IDLE and stallOut is forced to 0.
- Operand selection: A = selA ? pc : rs1Data. B is chosen per selB.
- Non-shift ops and shifts with shamt = B[4:0] = 0:
  - Complete in one cycle; the result is registered on the next edge.
  - SLT compares signed, SLTU compares unsigned; the result is 0 or 1, zero-extended.
  - ADD and SUB wrap modulo 2^32.
- FSM states: IDLE, SHIFT.
- IDLE, shift op with shamt N ≥ 1:
  - stallOut = 1.
  - On the edge: load the shift register with A and set count = N.
  - Outputs get a bubble (memOpOut = 00, rdOut = 0, aluToRegOut = 0); go to SHIFT.
- SHIFT:
  - Each edge shifts 1 bit (SLL: left with 0 fill; SRL: right with 0 fill; SRA: right with sign fill) and decrements count.
  - stallOut = 1 while count > 1.
  - At count = 1, stallOut = 0. On that edge the final shifted value goes to aluResult with rdOut, memOpOut, memSizeOut, aluToRegOut and storeData from the inputs, and the FSM returns to IDLE.
- The ID/EX inputs are held stable by stallOut, so they are sampled again at completion.
- stallIn = 1:
  - All output registers, the shift register, count and state hold.
  - stallOut = 1 (stallOut = internal stall OR stallIn).
- Priority: reset > stallIn > normal operation.

## Timing
- Non-shift latency: 1 cycle from ID/EX valid to EX/MEM registered.
- Shift latency: N + 1 edges; stallOut is high for exactly N cycles when stallIn = 0.
- Every cycle of stallIn extends the operation by one cycle without altering the result.
- stallOut is combinational from aluOp, selB, imm/rs2Data[4:0], state, count and stallIn. No input-to-output combinational path exists other than stallOut.
- Reset deasserted mid-shift: the FSM restarts in IDLE. The still-held shift op re-enters as a fresh operation.

## Structure
- Shared package (e.g. riscv_pkg) holds:
  - aluOp codes, selA/selB encodings, memOp encodings;
  - the FSM state type;
  - the bubble constant.
- Sub-module serial_shifter: load, A, N, direction/arith controls, hold (stallIn), and outputs done and result. It owns the shift register and count.
- ex_stage holds the operand muxes, the combinational ALU, the FSM glue and the EX/MEM registers.

## Test plan
- Reset asserted asynchronously mid-cycle -> all outputs 0 and stallOut = 0 immediately. After release, an ADD completes normally.
- ADD, selA = 0, selB = 01, rs1Data = 5, imm = 7, rd = 3, aluToReg = 1 -> next edge: aluResult = 12, rdOut = 3, aluToRegOut = 1.
- SLL, rs1Data = 1, rs2Data = 4 -> stallOut high 4 cycles, bubble on the first edge, aluResult = 16 on the 5th edge. SRA of 0x80000000 by 31 -> 0xFFFFFFFF after 32 edges.
- SLT vs SLTU, rs1Data = 0xFFFFFFFF, rs2Data = 1 -> SLT = 1, SLTU = 0. Shift with shamt 0 -> 1-cycle result, stallOut never high.
- stallIn pulsed 3 cycles during SRL of 0xF0 by 4 -> outputs and count frozen, completion delayed by 3 cycles, aluResult = 0x0F.
- Store, memOp = 10, memSize = 10, rs1Data = 0x100, imm = 8, rs2Data = 0xDEADBEEF -> aluResult = 0x108, storeData = 0xDEADBEEF, memOpOut = 10, memSizeOut = 10.
